// File: rtl/croc_board_inputs.sv
// croc_board_inputs
// Conditions asynchronous board switches/buttons for the SoC. Each channel is
// optionally inverted, synchronised into soc_clk, debounced by a small FSM
// with a window counter, and presented as a clean registered level.
//
// Build option: define BOARD_INPUTS_EDGE_EN to build the rise/fall pulses and
// the sticky change flags. Without it those outputs are tied low and ack_i
// is ignored. Level debouncing is the same in both builds.
//
// Ports:
//   soc_clk     block clock
//   rst_n       asynchronous active-low reset
//   raw_i       asynchronous board inputs, one bit per channel
//   bypass_i    quasi-static; 1 skips debouncing (level follows synchroniser)
//   ack_i       per-channel clear of changed_o
//   level_o     debounced level
//   rise_o      one-cycle pulse when level_o goes 0->1
//   fall_o      one-cycle pulse when level_o goes 1->0
//   changed_o   sticky "level changed since last ack"
//
// Per-channel FSM:
//   state      | meaning
//   STABLE_LO  | level 0, synchroniser agrees
//   WAIT_HI    | level 0, synchroniser high, window running
//   STABLE_HI  | level 1, synchroniser agrees
//   WAIT_LO    | level 1, synchroniser low, window running
module croc_board_inputs #(
  parameter int unsigned          NumInputs      = 8,
  parameter int unsigned          SyncStages     = 2,
  parameter int unsigned          DebounceCycles = 200000,
  parameter logic [NumInputs-1:0] InvertMask     = '0
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic [NumInputs-1:0] raw_i,
  input  logic                 bypass_i,
  input  logic [NumInputs-1:0] ack_i,
  output logic [NumInputs-1:0] level_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
  output logic [NumInputs-1:0] changed_o
);

  localparam int unsigned CntWidth = $clog2(DebounceCycles);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  // Synchroniser chain; polarity is fixed before the first flop.
  logic [SyncStages-1:0][NumInputs-1:0] sync_q;
  logic [NumInputs-1:0]                 sync_s;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw_i ^ InvertMask;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // Level implied by each channel's current FSM state.
  logic [NumInputs-1:0] fsm_lvl;

  for (genvar i = 0; i < NumInputs; i++) begin : g_chan
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // The window counts from 0 on the first disagreeing sample; the state
    // flips only once the terminal count has been reached and s still
    // disagrees, so the counter never has to hold DebounceCycles itself.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bypass_i) begin
        state_d = sync_s[i] ? STABLE_HI : STABLE_LO;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          STABLE_LO: begin
            cnt_d = '0;
            if (sync_s[i]) state_d = WAIT_HI;
          end
          WAIT_HI: begin
            if (!sync_s[i]) begin
              state_d = STABLE_LO;
              cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
              state_d = STABLE_HI;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntWidth'(1);
            end
          end
          STABLE_HI: begin
            cnt_d = '0;
            if (!sync_s[i]) state_d = WAIT_LO;
          end
          WAIT_LO: begin
            if (sync_s[i]) begin
              state_d = STABLE_HI;
              cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
              state_d = STABLE_LO;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntWidth'(1);
            end
          end
          default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign fsm_lvl[i] = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  end

  // Registered level keeps every output a flop output.
  logic [NumInputs-1:0] level_q;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= fsm_lvl;
    end
  end

  assign level_o = level_q;

`ifdef BOARD_INPUTS_EDGE_EN
  logic [NumInputs-1:0] rise_q, fall_q, changed_q, changed_d;

  // Set has priority over ack so a change arriving with an ack is not lost.
  assign changed_d = rise_q | fall_q | (changed_q & ~ack_i);

  // Pulses are computed from the value level_q is about to take, so they
  // line up with the level change; level_q is 0 out of reset, so nothing
  // pulses on reset release.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= '0;
    end else begin
      rise_q    <= fsm_lvl & ~level_q;
      fall_q    <= ~fsm_lvl & level_q;
      changed_q <= changed_d;
    end
  end

  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;
`else
  logic unused_ack;
  assign unused_ack = ^ack_i;

  assign rise_o    = '0;
  assign fall_o    = '0;
  assign changed_o = '0;
`endif

endmodule

// File: tb/tb_croc_board_inputs.sv
// Bench for croc_board_inputs: directed scenarios followed by random input
// traffic, all checked against a run-length reference model.
module tb_croc_board_inputs;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int D  = 8;
  localparam logic [N-1:0] INV = 4'b0001;
`ifdef BOARD_INPUTS_EDGE_EN
  localparam int EDGE_ON = 1;
`else
  localparam int EDGE_ON = 0;
`endif

  logic         soc_clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw_i;
  logic         bypass_i;
  logic [N-1:0] ack_i;
  logic [N-1:0] level_o, rise_o, fall_o, changed_o;

  always #5 soc_clk = ~soc_clk;

  croc_board_inputs #(
    .NumInputs     (N),
    .SyncStages    (SS),
    .DebounceCycles(D),
    .InvertMask    (INV)
  ) dut (
    .soc_clk  (soc_clk),
    .rst_n    (rst_n),
    .raw_i    (raw_i),
    .bypass_i (bypass_i),
    .ack_i    (ack_i),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rise_cnt [N];
  logic [N-1:0] eff;

  // Reference model: the debounced value flips once the synchronised input
  // has disagreed with it for D+1 consecutive samples; outputs are seen one
  // register later.
  logic [N-1:0] m_pipe [SS];
  logic [N-1:0] m_fl, m_lvl, m_rise, m_fall, m_chg;
  int           m_run [N];

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    m_fl = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_chg = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_clk();
    logic [N-1:0] s;
    s = m_pipe[SS-1];
    m_chg  = m_rise | m_fall | (m_chg & ~ack_i);
    m_rise = m_fl & ~m_lvl;
    m_fall = ~m_fl & m_lvl;
    m_lvl  = m_fl;
    for (int i = 0; i < N; i++) begin
      if (bypass_i) begin
        m_fl[i] = s[i];
        m_run[i] = 0;
      end else if (s[i] != m_fl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_fl[i] = s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = raw_i ^ INV;
  endtask

  function automatic logic [N-1:0] ee(logic [N-1:0] x);
    return (EDGE_ON != 0) ? x : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic [N-1:0] e);
    eff   = e;
    raw_i = e ^ INV;
  endtask

  task automatic step();
    @(posedge soc_clk);
    model_clk();
    cyc++;
    @(negedge soc_clk);
    for (int i = 0; i < N; i++) if (rise_o[i] === 1'b1) rise_cnt[i]++;
    chk("level",   32'(level_o),   32'(m_lvl));
    chk("rise",    32'(rise_o),    32'(ee(m_rise)));
    chk("fall",    32'(fall_o),    32'(ee(m_fall)));
    chk("changed", 32'(changed_o), 32'(ee(m_chg)));
  endtask

  task automatic wait_level(input int ch, input logic val, input int budget, output int at);
    at = -1;
    for (int j = 0; j < budget; j++) begin
      step();
      if (level_o[ch] === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic ack_all();
    ack_i = '1;
    step();
    ack_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t0, r0;
    for (int i = 0; i < N; i++) rise_cnt[i] = 0;
    rst_n    = 1'b0;
    bypass_i = 1'b0;
    ack_i    = '0;
    drive(4'hF);
    model_reset();

    // 1: reset with all inputs high, then latency from release
    repeat (3) @(negedge soc_clk);
    chk("t1_rst_level",   32'(level_o),   32'(0));
    chk("t1_rst_rise",    32'(rise_o),    32'(0));
    chk("t1_rst_fall",    32'(fall_o),    32'(0));
    chk("t1_rst_changed", 32'(changed_o), 32'(0));
    rst_n = 1'b1;
    t0 = cyc + 1;
    at = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (level_o === 4'hF) begin
        at = cyc;
        break;
      end
    end
    chk("t1_latency", 32'(at - t0), 32'(11));
    chk("t1_rise",    32'(rise_o),  32'(ee(4'hF)));
    step();
    chk("t1_rise_width", 32'(rise_o), 32'(0));
    ack_all();

    // 2: bounce on channel 0
    drive(eff & 4'b1110);
    wait_level(0, 1'b0, 20, at);
    step();
    ack_all();
    r0 = rise_cnt[0];
    drive(eff | 4'b0001);
    repeat (5) step();
    drive(eff & 4'b1110);
    repeat (2) step();
    drive(eff | 4'b0001);
    t0 = cyc + 1;
    at = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (at < 0 && level_o[0] === 1'b1) at = cyc;
    end
    chk("t2_latency", 32'(at - t0), 32'(11));
    chk("t2_rises",   32'(rise_cnt[0] - r0), 32'(EDGE_ON));
    ack_all();

    // 3: simultaneous rise on 1 and fall on 2
    drive(eff & 4'b1101);
    wait_level(1, 1'b0, 20, at);
    step();
    ack_all();
    drive((eff | 4'b0010) & 4'b1011);
    wait_level(1, 1'b1, 20, at);
    chk("t3_level2", 32'(level_o[2]), 32'(0));
    chk("t3_edges",  32'({rise_o, fall_o}), 32'({ee(4'b0010), ee(4'b0100)}));
    step();
    chk("t3_changed", 32'(changed_o), 32'(ee(4'b0110)));
    ack_all();

    // 4: ack coinciding with a new rise, then a lone ack
    drive(eff & 4'b1101);
    wait_level(1, 1'b0, 20, at);
    step();
    ack_all();
    drive(eff | 4'b0010);
    wait_level(1, 1'b1, 20, at);
    ack_i = 4'b0010;
    step();
    ack_i = '0;
    chk("t4_sticky", 32'(changed_o[1]), 32'(EDGE_ON));
    repeat (2) step();
    chk("t4_held", 32'(changed_o[1]), 32'(EDGE_ON));
    ack_i = 4'b0010;
    step();
    ack_i = '0;
    chk("t4_clear", 32'(changed_o[1]), 32'(0));

    // 5: bypass on channel 3, then reset in the middle of a window
    bypass_i = 1'b1;
    drive(eff & 4'b0111);
    t0 = cyc + 1;
    wait_level(3, 1'b0, 10, at);
    chk("t5_byp_fall_lat", 32'(at - t0),  32'(3));
    chk("t5_byp_fall",     32'(fall_o[3]), 32'(EDGE_ON));
    drive(eff | 4'b1000);
    t0 = cyc + 1;
    wait_level(3, 1'b1, 10, at);
    chk("t5_byp_rise_lat", 32'(at - t0),  32'(3));
    chk("t5_byp_rise",     32'(rise_o[3]), 32'(EDGE_ON));
    bypass_i = 1'b0;
    repeat (2) step();
    drive(eff & 4'b0111);
    repeat (7) step();
    chk("t5_pre_rst", 32'(level_o), 32'(4'b1011));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_level",   32'(level_o),   32'(0));
    chk("t5_rst_rise",    32'(rise_o),    32'(0));
    chk("t5_rst_fall",    32'(fall_o),    32'(0));
    chk("t5_rst_changed", 32'(changed_o), 32'(0));
    model_reset();

    // 6: polarity - channel 0 is inverted, so raw 0 debounces to level 1
    raw_i = '0;
    eff   = INV;
    @(negedge soc_clk);
    rst_n = 1'b1;
    t0 = cyc + 1;
    wait_level(0, 1'b1, 20, at);
    chk("t6_latency",  32'(at - t0), 32'(11));
    chk("t6_polarity", 32'(level_o), 32'(4'b0001));
    ack_all();

    // Random traffic: run lengths around the debounce window
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] e;
      e = eff;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) e[i] = ~e[i];
      drive(e);
      if ($urandom_range(0, 199) == 0) bypass_i = ~bypass_i;
      ack_i = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      step();
    end
    ack_i    = '0;
    bypass_i = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
